// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the parametrised UART transmitter.
package uart_pkg;

    // Parity selection as seen on the parity_mode input.
    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10,
        PAR_MARK = 2'b11
    } parity_e;

    // Transmit FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Width of a counter that must hold 0..clks-1 (never narrower than 1 bit).
    function automatic int baud_w(input int clks);
        return (clks <= 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Producer-side handshake into the transmitter FIFO.
// A word moves on a rising clk edge where tx_valid && tx_ready. tx_data is
// only meaningful while tx_valid is high; tx_ready does not depend on tx_valid.
interface uart_tx_param_if #(parameter int DATA_W = 8);
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding words waiting to be serialised.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO front end, baud counter and frame FSM.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_param_if.slave                bus,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    output logic                          tx_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output tx_state_e                     state_dbg
);
    localparam int BAUD_W = baud_w(CLKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_W);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    parity_e           mode_q, mode_d;
    logic              two_stop_q, two_stop_d;
    logic              par_bit_q, par_bit_d;
    logic              stop_idx_q, stop_idx_d;
    logic              tx_out_q, tx_out_d;

    logic              fifo_full, fifo_empty, pop, load, baud_tick, new_par;
    logic [DATA_W-1:0] fifo_rd;

    assign bus.tx_ready = !fifo_full;
    assign tx_out       = tx_out_q;
    assign busy         = (state_q != ST_IDLE);
    assign state_dbg    = state_q;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (bus.tx_valid && bus.tx_ready),
        .wr_data (bus.tx_data),
        .pop     (pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Parity of the word at the FIFO head, evaluated with the live mode at pop time.
    always_comb begin
        new_par = 1'b1;
        case (parity_e'(parity_mode))
            PAR_EVEN: new_par = ^fifo_rd;
            PAR_ODD:  new_par = ~^fifo_rd;
            default:  new_par = 1'b1;
        endcase
    end

    // Next-state logic; tx_out_d is the line level for the bit the FSM enters next.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        mode_d     = mode_q;
        two_stop_d = two_stop_q;
        par_bit_d  = par_bit_q;
        stop_idx_d = stop_idx_q;
        tx_out_d   = tx_out_q;
        load       = 1'b0;
        pop        = 1'b0;
        baud_tick  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

        if (state_q != ST_IDLE) baud_d = baud_tick ? '0 : baud_q + BAUD_W'(1);

        case (state_q)
            ST_IDLE: begin
                tx_out_d = 1'b1;
                if (!fifo_empty) load = 1'b1;
            end
            ST_START: begin
                if (baud_tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_out_d  = shift_q[0];
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_idx_q == IDX_W'(DATA_W - 1)) begin
                        if (mode_q != PAR_NONE) begin
                            state_d  = ST_PARITY;
                            tx_out_d = par_bit_q;
                        end else begin
                            state_d    = ST_STOP;
                            stop_idx_d = 1'b0;
                            tx_out_d   = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_out_d  = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (baud_tick) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                    tx_out_d   = 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_tick) begin
                    if (two_stop_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        tx_out_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                tx_out_d = 1'b1;
            end
        endcase

        // Pop the head and start a frame; frame settings are frozen here.
        if (load) begin
            pop        = 1'b1;
            state_d    = ST_START;
            baud_d     = '0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            shift_d    = fifo_rd;
            mode_d     = parity_e'(parity_mode);
            two_stop_d = two_stop;
            par_bit_d  = new_par;
            tx_out_d   = 1'b0;
        end
    end

    // FSM, datapath and line registers; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            mode_q     <= PAR_NONE;
            two_stop_q <= 1'b0;
            par_bit_q  <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_out_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            mode_q     <= mode_d;
            two_stop_q <= two_stop_d;
            par_bit_q  <= par_bit_d;
            stop_idx_q <= stop_idx_d;
            tx_out_q   <= tx_out_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: an 8-bit instance and a 5-bit instance, checked
// cycle by cycle against frames built from the word and its settings.
module tb_uart_tx_param;
    import uart_pkg::*;

    localparam int CPB8 = 4;
    localparam int CPB5 = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    uart_tx_param_if #(.DATA_W(8)) bus8 ();
    uart_tx_param_if #(.DATA_W(5)) bus5 ();

    logic [1:0] pm8 = 2'b00, pm5 = 2'b00;
    logic       ts8 = 1'b0,  ts5 = 1'b0;
    logic       tx8, tx5, busy8, busy5;
    logic [2:0] cnt8, cnt5;
    tx_state_e  state8, state5;

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB8), .FIFO_DEPTH(4)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8), .parity_mode(pm8), .two_stop(ts8),
        .tx_out(tx8), .busy(busy8), .fifo_count(cnt8), .state_dbg(state8)
    );

    uart_tx_param #(.DATA_W(5), .CLKS_PER_BIT(CPB5), .FIFO_DEPTH(4)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5), .parity_mode(pm5), .two_stop(ts5),
        .tx_out(tx5), .busy(busy5), .fifo_count(cnt5), .state_dbg(state5)
    );

    // ---------------- scoreboard ----------------
    // Entry = {two_stop, parity_mode[1:0], word[8:0]} expected for each accepted word.
    logic [11:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bit(s).
    function automatic void build_frame(input logic [8:0] w, input int dw, input logic [1:0] m,
                                        input logic two, output logic [15:0] bits, output int len);
        int ones;
        ones = 0;
        len  = 0;
        bits = '0;
        bits[len] = 1'b0; len++;
        for (int i = 0; i < dw; i++) begin
            bits[len] = w[i];
            ones += int'(w[i]);
            len++;
        end
        if (m == 2'b01)      begin bits[len] = ((ones % 2) == 1); len++; end
        else if (m == 2'b10) begin bits[len] = ((ones % 2) == 0); len++; end
        else if (m == 2'b11) begin bits[len] = 1'b1; len++; end
        bits[len] = 1'b1; len++;
        if (two) begin bits[len] = 1'b1; len++; end
    endfunction

    // ---------------- driver ----------------
    task automatic push_word(input logic [8:0] w, input logic [1:0] em, input logic et);
        int   budget;
        logic acc;
        budget = 0;
        @(negedge clk);
        bus8.tx_valid = 1'b1;
        bus8.tx_data  = w[7:0];
        do begin
            acc = bus8.tx_ready;
            @(posedge clk);
            if (!acc) @(negedge clk);
            budget++;
        end while (!acc && budget < 500);
        #1 bus8.tx_valid = 1'b0;
        check_eq("push_accepted", 32'(acc), 32'd1);
        if (acc) exp_q.push_back({et, em, w});
    endtask

    // ---------------- monitor ----------------
    // Finds the start bit within max_wait falling edges, then checks n frames
    // back to back with no gap, then an idle line.
    task automatic expect_frames(input int n, input int max_wait);
        logic [15:0] bits;
        int          len, waited;
        logic [11:0] fr;
        @(negedge clk);
        waited = 1;
        while (tx8 !== 1'b0 && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        check_eq("start_found", 32'(tx8), 32'd0);
        if (tx8 !== 1'b0) return;
        for (int f = 0; f < n; f++) begin
            check_eq("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() == 0) return;
            fr = exp_q.pop_front();
            build_frame(fr[8:0], 8, fr[10:9], fr[11], bits, len);
            for (int b = 0; b < len; b++) begin
                for (int c = 0; c < CPB8; c++) begin
                    if (!(f == 0 && b == 0 && c == 0)) @(negedge clk);
                    check_eq($sformatf("f%0d_w%0h_bit%0d", f, fr[8:0], b), 32'(tx8), 32'(bits[b]));
                    check_eq($sformatf("f%0d_busy", f), 32'(busy8), 32'd1);
                end
            end
        end
        @(negedge clk);
        check_eq("idle_line", 32'(tx8), 32'd1);
        check_eq("idle_busy", 32'(busy8), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #600000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] bits;
        int          len, lows, low_at, peak;
        bus8.tx_valid = 1'b0; bus8.tx_data = '0;
        bus5.tx_valid = 1'b0; bus5.tx_data = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check_eq("rst_tx_out", 32'(tx8), 32'd1);
        check_eq("rst_busy", 32'(busy8), 32'd0);
        check_eq("rst_ready", 32'(bus8.tx_ready), 32'd1);
        check_eq("rst_count", 32'(cnt8), 32'd0);
        check_eq("rst_tx5", 32'(tx5), 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_tx_out", 32'(tx8), 32'd1);

        // Test 1: 0xA5, no parity, one stop; start must appear at E+1
        push_word(9'h0A5, 2'b00, 1'b0);
        @(negedge clk);
        check_eq("pre_start_line", 32'(tx8), 32'd1);
        check_eq("pre_start_busy", 32'(busy8), 32'd0);
        expect_frames(1, 1);

        // Test 2: parity modes
        @(negedge clk); pm8 = 2'b01; ts8 = 1'b1;
        fork push_word(9'h007, 2'b01, 1'b1); expect_frames(1, 3); join
        @(negedge clk); pm8 = 2'b10; ts8 = 1'b0;
        fork push_word(9'h007, 2'b10, 1'b0); expect_frames(1, 3); join
        @(negedge clk); pm8 = 2'b11;
        fork push_word(9'h000, 2'b11, 1'b0); expect_frames(1, 3); join
        @(negedge clk); pm8 = 2'b00;

        // Test 3: hold valid with 0x01..0x06
        low_at = -1;
        peak   = 0;
        fork
            begin
                int   w, guard;
                logic r;
                w = 1; guard = 0;
                @(negedge clk);
                bus8.tx_valid = 1'b1;
                while (w <= 6 && guard < 2000) begin
                    bus8.tx_data = 8'(w);
                    r = bus8.tx_ready;
                    if (int'(cnt8) > peak) peak = int'(cnt8);
                    if (!r && low_at < 0) low_at = w - 1;
                    @(posedge clk);
                    if (r) begin
                        exp_q.push_back({1'b0, 2'b00, 9'(w)});
                        w++;
                    end
                    guard++;
                    @(negedge clk);
                end
                bus8.tx_valid = 1'b0;
            end
            expect_frames(6, 4);
        join
        check_eq("accepted_before_full", 32'(low_at), 32'd5);
        check_eq("fifo_peak", 32'(peak), 32'd4);

        // Test 4: reset during DATA bit 3 of 0x55 with two words queued
        push_word(9'h055, 2'b00, 1'b0);
        push_word(9'h0F0, 2'b00, 1'b0);
        push_word(9'h00F, 2'b00, 1'b0);
        repeat (16) @(negedge clk);
        check_eq("pre_rst_state", 32'(state8), 32'(ST_DATA));
        check_eq("pre_rst_bit3", 32'(tx8), 32'd0);
        check_eq("pre_rst_count", 32'(cnt8), 32'd2);
        #1 rst = 1'b0;
        #1;
        check_eq("async_rst_tx_out", 32'(tx8), 32'd1);
        check_eq("async_rst_count", 32'(cnt8), 32'd0);
        check_eq("async_rst_busy", 32'(busy8), 32'd0);
        exp_q.delete();
        @(negedge clk); rst = 1'b1;
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx8 !== 1'b1) lows++;
        end
        check_eq("no_frame_after_rst", 32'(lows), 32'd0);
        fork push_word(9'h03C, 2'b00, 1'b0); expect_frames(1, 3); join

        // Test 5: parity change mid-frame applies only from the next pop
        fork
            begin
                push_word(9'h0C3, 2'b00, 1'b0);
                push_word(9'h081, 2'b01, 1'b0);
                repeat (10) @(negedge clk);
                pm8 = 2'b01;
            end
            expect_frames(2, 3);
        join
        @(negedge clk); pm8 = 2'b00;

        // Randomized bursts with random settings
        for (int k = 0; k < 5; k++) begin
            int n;
            n = $urandom_range(1, 4);
            @(negedge clk);
            pm8 = 2'($urandom_range(0, 3));
            ts8 = 1'($urandom_range(0, 1));
            fork
                begin
                    for (int j = 0; j < n; j++) push_word(9'($urandom_range(0, 255)), pm8, ts8);
                end
                expect_frames(n, 4);
            join
        end
        @(negedge clk); pm8 = 2'b00; ts8 = 1'b0;

        // Test 6: DATA_W=5, CLKS_PER_BIT=2, 5'b10011 in odd mode
        @(negedge clk);
        pm5 = 2'b10;
        bus5.tx_valid = 1'b1;
        bus5.tx_data  = 5'b10011;
        @(posedge clk);
        #1 bus5.tx_valid = 1'b0;
        @(negedge clk);
        check_eq("w5_pre_start", 32'(tx5), 32'd1);
        build_frame(9'b000010011, 5, 2'b10, 1'b0, bits, len);
        for (int b = 0; b < len; b++) begin
            for (int c = 0; c < CPB5; c++) begin
                @(negedge clk);
                check_eq($sformatf("w5_bit%0d", b), 32'(tx5), 32'(bits[b]));
                check_eq("w5_busy", 32'(busy5), 32'd1);
            end
        end
        @(negedge clk);
        check_eq("w5_idle_line", 32'(tx5), 32'd1);
        check_eq("w5_idle_busy", 32'(busy5), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
